// File: rtl/spypath_sweep_ctrl.sv
// Spy-path sweep controller: precharge/fire each masked path `trials` times and count early-vs-golden mismatches.
// Optional macro SPYCTRL_ABORT_EN adds an `abort` input that cancels a running sweep.
module spypath_sweep_ctrl #(
  parameter int NUM_PATHS     = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CAPTURE_DLY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SPYCTRL_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic [NUM_PATHS-1:0] path_mask,
  input  logic [7:0]           trials,
  output logic [NUM_PATHS-1:0] launch,
  input  logic [NUM_PATHS-1:0] path_result,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [3:0]           res_path,
  output logic [7:0]           res_fails,
  output logic                 done
);
  localparam int IW = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_FIRE, S_CMP, S_REPORT, S_NEXT} state_t;

  state_t               r_state, w_nstate;
  logic [NUM_PATHS-1:0] r_sync1, r_sync2, r_mask;
  logic [7:0]           r_trials, r_trial, r_fails, r_cnt;
  logic [IW-1:0]        r_sel, w_first, w_next;
  logic                 w_next_any, r_done, r_early;
  logic [1:0]           r_stb_e, r_stb_g;
  logic                 w_abort, w_phase_end, w_stb_e, w_stb_g, w_sel_res, w_early_now, w_inc;

`ifdef SPYCTRL_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_phase_end = (r_cnt == 8'(SETTLE_CYCLES - 1));
  assign w_stb_e     = (r_state == S_FIRE) && (r_cnt == 8'(CAPTURE_DLY));
  assign w_stb_g     = (r_state == S_FIRE) && w_phase_end;
  assign w_sel_res   = r_sync2[r_sel];
  // Strobes trail the synchronizer by two cycles, so each sample reflects path_result
  // at its nominal fire cycle; the golden compare resolves one cycle after CMP.
  assign w_early_now = r_stb_e[1] ? w_sel_res : r_early;
  assign w_inc       = r_stb_g[1] && (w_early_now != w_sel_res);

  always_comb begin
    w_first    = '0;
    w_next     = '0;
    w_next_any = 1'b0;
    for (int i = NUM_PATHS - 1; i >= 0; i--)
      if (path_mask[i]) w_first = IW'(i);
    for (int i = NUM_PATHS - 1; i >= 0; i--)
      if (r_mask[i] && (i > int'(r_sel))) begin
        w_next     = IW'(i);
        w_next_any = 1'b1;
      end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:   if (start && (|path_mask) && (trials != 8'd0)) w_nstate = S_PRE;
      S_PRE:    if (w_phase_end) w_nstate = S_FIRE;
      S_FIRE:   if (w_phase_end) w_nstate = S_CMP;
      S_CMP:    w_nstate = ((r_trial + 8'd1) < r_trials) ? S_PRE : S_REPORT;
      S_REPORT: if (res_ready) w_nstate = S_NEXT;
      S_NEXT:   w_nstate = w_next_any ? S_PRE : S_IDLE;
      default:  w_nstate = S_IDLE;
    endcase
    if (w_abort) w_nstate = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_mask   <= '0;
      r_trials <= '0;
      r_trial  <= '0;
      r_fails  <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_done   <= 1'b0;
      r_early  <= 1'b0;
      r_stb_e  <= '0;
      r_stb_g  <= '0;
    end else begin
      r_sync1 <= path_result;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      r_stb_e <= {r_stb_e[0], w_stb_e};
      r_stb_g <= {r_stb_g[0], w_stb_g};
      if (r_stb_e[1]) r_early <= w_sel_res;
      if (w_inc) r_fails <= r_fails + 8'd1;
      if ((r_state == S_PRE) || (r_state == S_FIRE))
        r_cnt <= w_phase_end ? 8'd0 : r_cnt + 8'd1;
      else
        r_cnt <= 8'd0;
      case (r_state)
        S_IDLE: if (start) begin
          if ((path_mask == '0) || (trials == 8'd0)) begin
            r_done <= 1'b1;
          end else begin
            r_mask   <= path_mask;
            r_trials <= trials;
            r_sel    <= w_first;
            r_trial  <= 8'd0;
            r_fails  <= 8'd0;
          end
        end
        S_CMP: r_trial <= r_trial + 8'd1;
        S_NEXT: if (w_next_any) begin
          r_sel   <= w_next;
          r_trial <= 8'd0;
          r_fails <= 8'd0;
        end else begin
          r_done <= 1'b1;
        end
        default: ;
      endcase
      if (w_abort) begin
        r_done  <= 1'b1;
        r_stb_e <= '0;
        r_stb_g <= '0;
      end
    end
  end

  always_comb begin
    launch = '0;
    if ((r_state == S_FIRE) && !w_abort) launch[r_sel] = 1'b1;
  end

  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_REPORT) && !w_abort;
  assign res_path  = 4'(r_sel);
  assign res_fails = r_fails + 8'(w_inc);
  assign done      = r_done;

endmodule

// File: tb/tb_spypath_sweep_ctrl.sv
// Directed bench for spypath_sweep_ctrl; paths are modelled as launch delayed by a per-path cycle count.
module tb_spypath_sweep_ctrl;
  localparam int NP = 4;
  localparam int S  = 8;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic [NP-1:0] path_mask = '0;
  logic [7:0]    trials = '0;
  logic [NP-1:0] launch, path_result;
  logic          busy, res_valid, done;
  logic [3:0]    res_path;
  logic [7:0]    res_fails;
`ifdef SPYCTRL_ABORT_EN
  logic          abort = 1'b0;
`endif

  int          checks = 0, errors = 0;
  int          dly [NP] = '{0, 0, 0, 0};
  logic [15:0] hist [NP];
  int          nres, ndone, done_cyc;
  int          res_p [8];
  int          res_f [8];

  always #5 clk = ~clk;

  spypath_sweep_ctrl #(.NUM_PATHS(NP), .SETTLE_CYCLES(S), .CAPTURE_DLY(1)) dut (
    .clk(clk), .rst(rst),
`ifdef SPYCTRL_ABORT_EN
    .abort(abort),
`endif
    .start(start), .path_mask(path_mask), .trials(trials), .launch(launch),
    .path_result(path_result), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_path(res_path), .res_fails(res_fails), .done(done)
  );

  always @(posedge clk)
    for (int p = 0; p < NP; p++) hist[p] <= rst ? 16'h0 : {hist[p][14:0], launch[p]};

  always_comb begin
    path_result = '0;
    for (int p = 0; p < NP; p++)
      path_result[p] = (dly[p] == 0) ? launch[p] : hist[p][dly[p] - 1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_null(input logic [3:0] m, input logic [7:0] t, input string tag);
    path_mask = m; trials = t; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " launch"}, 32'(launch), 32'd0);
    @(negedge clk);
    chk({tag, " done end"}, 32'(done), 32'd0);
    chk({tag, " busy end"}, 32'(busy), 32'd0);
  endtask

  // Runs one sweep from the current negedge; d = res_ready hold-off cycles per report.
  task automatic run_sweep(input logic [3:0] m, input logic [7:0] t, input int d,
                           input int st_every, input string tag);
    int cyc, rcnt;
    logic [3:0] hp;
    logic [7:0] hf;
    bit bad_rep, bad_launch, bad_busy, noisy;
    nres = 0; ndone = 0; done_cyc = 0; rcnt = 0; hp = '0; hf = '0;
    bad_rep = 0; bad_launch = 0; bad_busy = 0; noisy = 0;
    path_mask = m; trials = t; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 4000 && ndone == 0) begin
      if (((launch & (launch - 4'd1)) != 4'd0) || ((launch & ~m) != 4'd0)) bad_launch = 1;
      if (done) begin
        ndone = 1; done_cyc = cyc;
        if (busy) bad_busy = 1;
      end else if (!busy) bad_busy = 1;
      if (res_valid) begin
        if (launch != 4'd0) bad_rep = 1;
        if (rcnt == 0) begin hp = res_path; hf = res_fails; end
        else if (res_path !== hp || res_fails !== hf) bad_rep = 1;
        if (rcnt >= d) begin
          res_ready = 1'b1;
          if (nres < 8) begin res_p[nres] = int'(hp); res_f[nres] = int'(hf); end
          nres++; rcnt = 0;
        end else begin
          res_ready = 1'b0; rcnt++;
        end
      end else res_ready = 1'b0;
      start = (st_every > 0) && (cyc % st_every == 0) && busy && !done;
      @(negedge clk); cyc++;
    end
    start = 1'b0; res_ready = 1'b0;
    chk({tag, " done count"}, 32'(ndone), 32'd1);
    chk({tag, " report stable"}, 32'(bad_rep), 32'd0);
    chk({tag, " launch onehot"}, 32'(bad_launch), 32'd0);
    chk({tag, " busy span"}, 32'(bad_busy), 32'd0);
    repeat (4) begin
      if (done || busy || res_valid) noisy = 1;
      @(negedge clk);
    end
    chk({tag, " quiet after"}, 32'(noisy), 32'd0);
  endtask

  initial begin
    int  w;
    bit  seen;
    @(negedge clk);
    chk("rst launch", 32'(launch), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst res_path", 32'(res_path), 32'd0);
    chk("rst res_fails", 32'(res_fails), 32'd0);
    rst = 1'b0;
    run_null(4'b0000, 8'd3, "mask0");
    run_null(4'b1111, 8'd0, "trials0");

    dly = '{0, 0, 0, 0};
    run_sweep(4'b0101, 8'd3, 0, 0, "p32");
    chk("p32 nres", 32'(nres), 32'd2);
    chk("p32 path a", 32'(res_p[0]), 32'd0);
    chk("p32 fails a", 32'(res_f[0]), 32'd0);
    chk("p32 path b", 32'(res_p[1]), 32'd2);
    chk("p32 fails b", 32'(res_f[1]), 32'd0);
    chk("p32 cycles", 32'(done_cyc), 32'(2 * (3 * (2 * S + 1) + 2) + 1));

    dly = '{0, 0, 5, 0};
    run_sweep(4'b0101, 8'd10, 0, 0, "p33");
    chk("p33 nres", 32'(nres), 32'd2);
    chk("p33 path a", 32'(res_p[0]), 32'd0);
    chk("p33 fails a", 32'(res_f[0]), 32'd0);
    chk("p33 path b", 32'(res_p[1]), 32'd2);
    chk("p33 fails b", 32'(res_f[1]), 32'd10);
    chk("p33 cycles", 32'(done_cyc), 32'd345);

    dly = '{0, 1, 0, 2};
    run_sweep(4'b1010, 8'd2, 20, 7, "p35");
    chk("p35 nres", 32'(nres), 32'd2);
    chk("p35 path a", 32'(res_p[0]), 32'd1);
    chk("p35 fails a", 32'(res_f[0]), 32'd0);
    chk("p35 path b", 32'(res_p[1]), 32'd3);
    chk("p35 fails b", 32'(res_f[1]), 32'd2);
    chk("p35 cycles", 32'(done_cyc), 32'd113);

    dly = '{0, 0, 0, 5};
    path_mask = 4'b0001; trials = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (launch[0] !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    chk("p36 fire reached", 32'(launch[0]), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("p36 async launch", 32'(launch), 32'd0);
    chk("p36 async busy", 32'(busy), 32'd0);
    chk("p36 async res_valid", 32'(res_valid), 32'd0);
    seen = 0;
    repeat (3) begin @(negedge clk); if (done) seen = 1; end
    chk("p36 no done", 32'(seen), 32'd0);
    rst = 1'b0;
    run_sweep(4'b1000, 8'd1, 0, 0, "p36 after");
    chk("p36 nres", 32'(nres), 32'd1);
    chk("p36 path", 32'(res_p[0]), 32'd3);
    chk("p36 fails", 32'(res_f[0]), 32'd1);
    chk("p36 cycles", 32'(done_cyc), 32'd20);

`ifdef SPYCTRL_ABORT_EN
    dly = '{0, 0, 0, 0};
    path_mask = 4'b0011; trials = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!res_valid && w < 200) begin @(negedge clk); w++; end
    chk("p37 first result", 32'(res_valid), 32'd1);
    chk("p37 first path", 32'(res_path), 32'd0);
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("p37 done", 32'(done), 32'd1);
    chk("p37 busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || done || launch != 4'd0) seen = 1;
    end
    chk("p37 quiet", 32'(seen), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
